// File: rtl/combi_isa_tracker_if.sv
// Decode-side bus of the ISA tracker.
//   master : the pipeline, which drives the instruction and control and reads the ISA steering.
//   slave  : the tracker itself.
// Signals:
//   instrD, instrValidD, stallD, flushD    Decode instruction and its qualifiers
//   forceModeE, forceArmE                  explicit mode change requested by Execute
//   trapAck                                clears the sticky trap
//   armD, ambiguousD, illegalD, modeSwitchD, trapD   tracker results
interface combi_isa_tracker_if;
  logic [31:0] instrD;
  logic        instrValidD;
  logic        stallD;
  logic        flushD;
  logic        forceModeE;
  logic        forceArmE;
  logic        trapAck;
  logic        armD;
  logic        ambiguousD;
  logic        illegalD;
  logic        modeSwitchD;
  logic        trapD;

  modport master (
    output instrD, instrValidD, stallD, flushD, forceModeE, forceArmE, trapAck,
    input  armD, ambiguousD, illegalD, modeSwitchD, trapD
  );

  modport slave (
    input  instrD, instrValidD, stallD, flushD, forceModeE, forceArmE, trapAck,
    output armD, ambiguousD, illegalD, modeSwitchD, trapD
  );
endinterface

// File: rtl/combi_isa_tracker.sv
// Registered ARM / RISC-V mode tracker for the Decode stage.
// Each accepted instruction is classed as legal in both ISAs, in the current ISA only,
// in the other ISA only, or in neither. The mode flips after SWITCH_THRESH consecutive
// other-ISA-only words. Execute can force the mode directly. ILL_LIMIT consecutive
// illegal words raise a sticky trap, which is cleared by trapAck.
// Ports:
//   clk    clock
//   reset  asynchronous, active-high
//   bus    combi_isa_tracker_if.slave (see the interface for the signal list)
module combi_isa_tracker #(
  parameter bit RESET_ARM     = 1'b0,
  parameter int CONF_W        = 2,
  parameter int SWITCH_THRESH = 2,
  parameter int ILL_W         = 2,
  parameter int ILL_LIMIT     = 3
) (
  input  logic                clk,
  input  logic                reset,
  combi_isa_tracker_if.slave  bus
);

  logic              modeQ, mode_d;
  logic [CONF_W-1:0] confQ, conf_d;
  logic [ILL_W-1:0]  illQ,  ill_d;
  logic              trapQ, trap_d;

  logic rv_legal, arm_legal;
  logic accept, acc;
  logic cls_ill, cls_other;
  logic conf_hit, ill_at_max, trap_set, switch_now;

  // RISC-V legality: whitelisted opcodes; OP and OP-IMM also need a whitelisted funct3.
  always_comb begin
    rv_legal = 1'b0;
    unique case (bus.instrD[6:0])
      7'b0000011, 7'b0100011, 7'b1100011, 7'b1101111: rv_legal = 1'b1;
      7'b0110011, 7'b0010011:
        rv_legal = bus.instrD[14:12] inside {3'b000, 3'b010, 3'b110, 3'b111};
      default: rv_legal = 1'b0;
    endcase
  end

  // ARM legality: class 11 is never legal; class 00 only for the supported data-processing opcodes.
  always_comb begin
    arm_legal = 1'b1;
    if (bus.instrD[27:26] == 2'b11)
      arm_legal = 1'b0;
    else if (bus.instrD[27:26] == 2'b00)
      arm_legal = bus.instrD[24:21] inside {4'b0100, 4'b0010, 4'b0000, 4'b1100};
  end

  assign accept = bus.instrValidD & ~bus.stallD & ~bus.flushD;
  // A force overrides the class of the instruction, so classification only counts without one.
  assign acc    = accept & ~bus.forceModeE;

  assign cls_ill   = ~rv_legal & ~arm_legal;
  assign cls_other = modeQ ? (rv_legal & ~arm_legal) : (arm_legal & ~rv_legal);

  // confQ+1 >= SWITCH_THRESH rewritten as a compare so the counter never has to overflow.
  assign conf_hit   = (confQ >= CONF_W'(SWITCH_THRESH - 1));
  assign ill_at_max = &illQ;

  // Next-state logic
  always_comb begin
    mode_d     = modeQ;
    conf_d     = confQ;
    ill_d      = illQ;
    trap_set   = 1'b0;
    switch_now = 1'b0;
    if (bus.forceModeE) begin
      mode_d = bus.forceArmE;
      conf_d = '0;
      ill_d  = '0;
    end else if (accept) begin
      if (cls_ill) begin
        // Saturating count; the trap fires only at the increment that lands on ILL_LIMIT.
        if (!ill_at_max) begin
          ill_d    = illQ + 1'b1;
          trap_set = (illQ == ILL_W'(ILL_LIMIT - 1));
        end
      end else if (cls_other && conf_hit) begin
        mode_d     = ~modeQ;
        conf_d     = '0;
        ill_d      = '0;
        switch_now = 1'b1;
      end else if (cls_other) begin
        conf_d = confQ + 1'b1;
        ill_d  = '0;
      end else begin
        conf_d = '0;
        ill_d  = '0;
      end
    end
    if (bus.trapAck && !trap_set)
      ill_d = '0;
  end

  // A new trap takes precedence over an acknowledge in the same cycle.
  assign trap_d = trap_set | (trapQ & ~bus.trapAck);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      modeQ <= RESET_ARM;
      confQ <= '0;
      illQ  <= '0;
      trapQ <= 1'b0;
    end else begin
      modeQ <= mode_d;
      confQ <= conf_d;
      illQ  <= ill_d;
      trapQ <= trap_d;
    end
  end

  // Outputs. On a switch the instruction already decodes in the new ISA this cycle.
  always_comb begin
    bus.armD        = modeQ;
    bus.modeSwitchD = 1'b0;
    if (bus.forceModeE) begin
      bus.armD        = bus.forceArmE;
      bus.modeSwitchD = bus.forceArmE ^ modeQ;
    end else if (switch_now) begin
      bus.armD        = ~modeQ;
      bus.modeSwitchD = 1'b1;
    end
    bus.ambiguousD = acc & rv_legal & arm_legal;
    bus.illegalD   = acc & cls_ill;
    bus.trapD      = trapQ;
  end

endmodule

// File: tb/tb_combi_isa_tracker.sv
module tb_combi_isa_tracker;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;

  combi_isa_tracker_if bus();

  combi_isa_tracker dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  localparam logic [31:0] RV_ONLY  = 32'h0C000093;
  localparam logic [31:0] ARM_ONLY = 32'hE0821005;
  localparam logic [31:0] ARM_ONL2 = 32'h04000000;
  localparam logic [31:0] BOTH     = 32'h00500093;
  localparam logic [31:0] ILL_ALL  = 32'hFFFFFFFF;
  localparam logic [31:0] ILL_RV3  = 32'h0C001033; // OP with funct3 001, ARM class 11
  localparam logic [31:0] ILL_ARM0 = 32'h01A00000; // ARM class 00 opcode 1101, RV opcode 0

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Apply inputs just after a falling edge; checks follow 1 time unit later.
  task automatic drv(input logic [31:0] i, input logic v, input logic st, input logic fl,
                     input logic fm, input logic fa, input logic ak);
    @(negedge clk);
    bus.instrD      = i;
    bus.instrValidD = v;
    bus.stallD      = st;
    bus.flushD      = fl;
    bus.forceModeE  = fm;
    bus.forceArmE   = fa;
    bus.trapAck     = ak;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    bus.instrD = '0; bus.instrValidD = 0; bus.stallD = 0; bus.flushD = 0;
    bus.forceModeE = 0; bus.forceArmE = 0; bus.trapAck = 0;
    @(negedge clk); #1;
    chk("rst_arm", bus.armD, 1'b0);
    chk("rst_trap", bus.trapD, 1'b0);
    chk("rst_sw", bus.modeSwitchD, 1'b0);
    reset = 1'b0;

    // RISC-V only in RISC-V mode: OWN
    drv(RV_ONLY, 1, 0, 0, 0, 0, 0);
    chk("own_arm", bus.armD, 1'b0); chk("own_sw", bus.modeSwitchD, 1'b0);
    chk("own_amb", bus.ambiguousD, 1'b0); chk("own_ill", bus.illegalD, 1'b0);
    // Two ARM-only words switch the mode
    drv(ARM_ONLY, 1, 0, 0, 0, 0, 0);
    chk("oth1_arm", bus.armD, 1'b0); chk("oth1_sw", bus.modeSwitchD, 1'b0);
    drv(ARM_ONLY, 1, 0, 0, 0, 0, 0);
    chk("oth2_arm", bus.armD, 1'b1); chk("oth2_sw", bus.modeSwitchD, 1'b1);
    // Stall: mode is visible, nothing qualified
    drv(ARM_ONLY, 1, 1, 0, 0, 0, 0);
    chk("stall_arm", bus.armD, 1'b1); chk("stall_sw", bus.modeSwitchD, 1'b0);
    chk("stall_amb", bus.ambiguousD, 1'b0);
    // Ambiguous word in ARM mode
    drv(BOTH, 1, 0, 0, 0, 0, 0);
    chk("amb_amb", bus.ambiguousD, 1'b1); chk("amb_arm", bus.armD, 1'b1);
    chk("amb_sw", bus.modeSwitchD, 1'b0);
    // OTHER, AMB clears confidence, OTHER again: no switch
    drv(RV_ONLY, 1, 0, 0, 0, 0, 0);
    chk("c1_arm", bus.armD, 1'b1); chk("c1_sw", bus.modeSwitchD, 1'b0);
    drv(BOTH, 1, 0, 0, 0, 0, 0);
    drv(RV_ONLY, 1, 0, 0, 0, 0, 0);
    chk("c2_arm", bus.armD, 1'b1); chk("c2_sw", bus.modeSwitchD, 1'b0);
    // Three illegal words raise the trap; confidence holds through them
    drv(ILL_ALL, 1, 0, 0, 0, 0, 0);
    chk("i1_ill", bus.illegalD, 1'b1); chk("i1_arm", bus.armD, 1'b1);
    drv(ILL_ALL, 1, 0, 0, 0, 0, 0);
    chk("i2_ill", bus.illegalD, 1'b1);
    drv(ILL_ALL, 1, 0, 0, 0, 0, 0);
    chk("i3_ill", bus.illegalD, 1'b1); chk("i3_trap", bus.trapD, 1'b0);
    drv(RV_ONLY, 1, 0, 0, 0, 0, 0);
    chk("i4_trap", bus.trapD, 1'b1); chk("i4_arm", bus.armD, 1'b0);
    chk("i4_sw", bus.modeSwitchD, 1'b1); chk("i4_ill", bus.illegalD, 1'b0);
    // Another qualifying ILL together with trapAck: set wins
    drv(ILL_ALL, 1, 0, 0, 0, 0, 0);
    chk("j1_trap", bus.trapD, 1'b1);
    drv(ILL_ALL, 1, 0, 0, 0, 0, 0);
    drv(ILL_ALL, 1, 0, 0, 0, 0, 1);
    chk("j3_ill", bus.illegalD, 1'b1);
    drv('0, 0, 0, 0, 0, 0, 1);
    chk("setwins_trap", bus.trapD, 1'b1);
    drv('0, 0, 0, 0, 0, 0, 0);
    chk("ack_trap", bus.trapD, 1'b0);
    // trapAck alone clears the illegal count
    drv(ILL_ALL, 1, 0, 0, 0, 0, 0);
    drv(ILL_ALL, 1, 0, 0, 0, 0, 0);
    drv('0, 0, 0, 0, 0, 0, 1);
    drv(ILL_ALL, 1, 0, 0, 0, 0, 0);
    chk("k_ill", bus.illegalD, 1'b1);
    drv(ILL_RV3, 1, 0, 0, 0, 0, 0);
    chk("rvf3_ill", bus.illegalD, 1'b1); chk("k_trap", bus.trapD, 1'b0);
    // Force to ARM during stall; class ignored
    drv(ILL_ALL, 1, 1, 0, 1, 1, 0);
    chk("f1_arm", bus.armD, 1'b1); chk("f1_sw", bus.modeSwitchD, 1'b1);
    chk("f1_ill", bus.illegalD, 1'b0); chk("f1_trap", bus.trapD, 1'b0);
    drv(RV_ONLY, 1, 1, 0, 0, 0, 0);
    chk("f2_arm", bus.armD, 1'b1); chk("f2_sw", bus.modeSwitchD, 1'b0);
    drv(ILL_ARM0, 1, 0, 0, 0, 0, 0);
    chk("arm00_ill", bus.illegalD, 1'b1); chk("arm00_arm", bus.armD, 1'b1);
    drv('0, 0, 0, 0, 1, 1, 0);
    chk("fsame_arm", bus.armD, 1'b1); chk("fsame_sw", bus.modeSwitchD, 1'b0);
    drv(ARM_ONL2, 1, 1, 0, 1, 0, 0);
    chk("f3_arm", bus.armD, 1'b0); chk("f3_sw", bus.modeSwitchD, 1'b1);
    // Flush with an OTHER word changes nothing
    drv(ARM_ONL2, 1, 0, 1, 0, 0, 0);
    chk("fl_arm", bus.armD, 1'b0); chk("fl_sw", bus.modeSwitchD, 1'b0);
    chk("fl_amb", bus.ambiguousD, 1'b0); chk("fl_ill", bus.illegalD, 1'b0);
    drv(ARM_ONL2, 1, 0, 0, 0, 0, 0);
    chk("p1_arm", bus.armD, 1'b0); chk("p1_sw", bus.modeSwitchD, 1'b0);
    // Would switch now; asynchronous reset drops it without a clock edge
    drv(ARM_ONL2, 1, 0, 0, 0, 0, 0);
    chk("p2_arm", bus.armD, 1'b1); chk("p2_sw", bus.modeSwitchD, 1'b1);
    #1 reset = 1'b1;
    #1;
    chk("arst_arm", bus.armD, 1'b0); chk("arst_sw", bus.modeSwitchD, 1'b0);
    bus.instrValidD = 1'b0;
    @(negedge clk); reset = 1'b0;
    drv(ARM_ONL2, 1, 0, 0, 0, 0, 0);
    chk("r1_arm", bus.armD, 1'b0); chk("r1_sw", bus.modeSwitchD, 1'b0);
    drv(ARM_ONL2, 1, 0, 0, 0, 0, 0);
    chk("r2_arm", bus.armD, 1'b1); chk("r2_sw", bus.modeSwitchD, 1'b1);
    drv('0, 0, 0, 0, 0, 0, 0);
    chk("r3_arm", bus.armD, 1'b1); chk("r3_sw", bus.modeSwitchD, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
